// File: rtl/gate_response_monitor.sv
// gate_response_monitor
// ---------------------------------------------------------------------------
// Checker for the output side of a 2-input NOR under test. It registers the
// stimulus pair (a, b) and the gate response q once, then works entirely from
// those registered copies:
//   * counts q transitions while monitoring and accumulates an energy figure
//     (ENERGY_PER_TOGGLE per transition) as a power estimate;
//   * waits for the stimulus to hold still for SETTLE_CYC cycles, then checks
//     q against NOR(a, b), counting failures and capturing the first one.
//
// Optional build macro: GATE_MON_HAZARD_EN adds hazard_cnt, counting settle
// windows in which q toggled two or more times (a glitch).
//
// Ports
//   clk          in   rising-edge system clock
//   reset_L      in   asynchronous active-low reset
//   en           in   monitoring enable; low sends the FSM to IDLE
//   clr          in   synchronous clear of counters and error capture
//   a, b         in   stimulus as driven to the gate under test
//   q            in   gate response
//   toggle_cnt   out  q transitions seen while enabled (saturating)
//   power_acc    out  toggle energy accumulator (saturating)
//   err_cnt      out  failed checks (saturating)
//   err_flag     out  sticky, set by the first failed check
//   first_err_ab out  {a,b} at the first failed check
//   check_valid  out  one-cycle pulse when a check is performed
//   state        out  FSM state: IDLE=0, SETTLE=1, CHECK=2, STABLE=3
//   hazard_cnt   out  glitchy settle windows (GATE_MON_HAZARD_EN only)
//
// Handshake: there is none; check_valid is a qualifier pulse. The error
// outputs reflect a check on the clock edge that ends its check_valid cycle.
// ---------------------------------------------------------------------------
module gate_response_monitor #(
  parameter int CNT_W             = 16,
  parameter int PWR_W             = 24,
  parameter int ENERGY_PER_TOGGLE = 1,
  parameter int SETTLE_CYC        = 2
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             q,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [PWR_W-1:0] power_acc,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic [1:0]       first_err_ab,
  output logic             check_valid,
`ifdef GATE_MON_HAZARD_EN
  output logic [CNT_W-1:0] hazard_cnt,
`endif
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_STABLE = 2'd3
  } state_e;

  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYC - 1);
  localparam logic [PWR_W:0]   ENERGY      = (PWR_W+1)'(ENERGY_PER_TOGGLE);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

  state_e           state_q, state_d;
  logic             a_r_q, b_r_q, q_r_q, q_prev_q;
  logic [1:0]       ab_prev_q, ab_prev_d;
  logic [3:0]       settle_q, settle_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic [PWR_W-1:0] pwr_q, pwr_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             flag_q, flag_d;
  logic [1:0]       first_q, first_d;

  logic [1:0]       ab_r;
  logic             ab_changed, toggle, mismatch, do_check;
  logic [PWR_W:0]   pwr_sum;

  assign ab_r       = {a_r_q, b_r_q};
  assign ab_changed = (ab_r != ab_prev_q);
  assign toggle     = en && (state_q != S_IDLE) && (q_r_q != q_prev_q);
  assign mismatch   = (q_r_q != ~(a_r_q | b_r_q));
  assign do_check   = en && (state_q == S_CHECK);
  // One extra bit catches accumulator overflow for saturation.
  assign pwr_sum    = {1'b0, pwr_q} + ENERGY;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    ab_prev_d = ab_prev_q;
    case (state_q)
      S_IDLE: begin
        ab_prev_d = ab_r;
        if (en) begin
          settle_d = SETTLE_INIT;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (ab_changed) begin
          // Any movement restarts the settle window, even on its last cycle.
          ab_prev_d = ab_r;
          settle_d  = SETTLE_INIT;
        end else if (settle_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_CHECK: state_d = S_STABLE;
      S_STABLE: begin
        if (ab_changed) begin
          ab_prev_d = ab_r;
          settle_d  = SETTLE_INIT;
          state_d   = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!en) state_d = S_IDLE;
  end

  // Counters and error capture; clr takes priority over any increment.
  always_comb begin
    tog_d   = tog_q;
    pwr_d   = pwr_q;
    err_d   = err_q;
    flag_d  = flag_q;
    first_d = first_q;
    if (clr) begin
      tog_d   = '0;
      pwr_d   = '0;
      err_d   = '0;
      flag_d  = 1'b0;
      first_d = 2'b00;
    end else begin
      if (toggle) begin
        if (tog_q != '1) tog_d = tog_q + ONE_C;
        pwr_d = pwr_sum[PWR_W] ? '1 : pwr_sum[PWR_W-1:0];
      end
      if (do_check && mismatch) begin
        if (err_q != '1) err_d = err_q + ONE_C;
        flag_d = 1'b1;
        if (!flag_q) first_d = ab_r;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= S_IDLE;
      a_r_q     <= 1'b0;
      b_r_q     <= 1'b0;
      q_r_q     <= 1'b0;
      q_prev_q  <= 1'b0;
      ab_prev_q <= 2'b00;
      settle_q  <= 4'd0;
      tog_q     <= '0;
      pwr_q     <= '0;
      err_q     <= '0;
      flag_q    <= 1'b0;
      first_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      a_r_q     <= a;
      b_r_q     <= b;
      q_r_q     <= q;
      // Tracked even in IDLE so enabling never sees a stale previous value.
      q_prev_q  <= q_r_q;
      ab_prev_q <= ab_prev_d;
      settle_q  <= settle_d;
      tog_q     <= tog_d;
      pwr_q     <= pwr_d;
      err_q     <= err_d;
      flag_q    <= flag_d;
      first_q   <= first_d;
    end
  end

`ifdef GATE_MON_HAZARD_EN
  // Per-window toggle tally, saturating at 2; the hazard counter bumps on the
  // second toggle of a window, so each glitchy window counts once.
  logic [1:0]       tally_q, tally_d;
  logic [CNT_W-1:0] haz_q, haz_d;
  logic             win_entry, win_toggle;

  assign win_entry  = (state_d == S_SETTLE) && (state_q != S_SETTLE);
  assign win_toggle = toggle && (state_q == S_SETTLE);

  always_comb begin
    tally_d = tally_q;
    haz_d   = haz_q;
    if (win_entry) begin
      tally_d = 2'd0;
    end else if (win_toggle && tally_q != 2'd2) begin
      tally_d = tally_q + 2'd1;
    end
    if (clr) begin
      haz_d = '0;
    end else if (win_toggle && tally_q == 2'd1 && haz_q != '1) begin
      haz_d = haz_q + ONE_C;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      tally_q <= 2'd0;
      haz_q   <= '0;
    end else begin
      tally_q <= tally_d;
      haz_q   <= haz_d;
    end
  end

  assign hazard_cnt = haz_q;
`endif

  assign toggle_cnt   = tog_q;
  assign power_acc    = pwr_q;
  assign err_cnt      = err_q;
  assign err_flag     = flag_q;
  assign first_err_ab = first_q;
  assign check_valid  = do_check;
  assign state        = state_q;

endmodule

// File: doc/gate_response_monitor.md
Name: gate_response_monitor

Overview:
- Sequential checker that sits on the output side of a 2-input NOR under test, opposite the stimulus tester.
- Samples the stimulus pair (a, b) and the gate response q every clock.
- Counts q transitions and accumulates a per-toggle energy figure as a power estimate.
- After inputs settle, checks q against NOR(a, b), then counts and captures mismatches.

Parameters:
- CNT_W, 16, width of toggle and error counters.
- PWR_W, 24, width of the power accumulator.
- ENERGY_PER_TOGGLE, 1, energy units added per q transition; must be less than 2^PWR_W.
- SETTLE_CYC, 2, cycles the registered inputs must stay stable before a check; must be 1 to 15.

Ports:
- clk, input, 1, single system clock; rising edge.
- reset_L, input, 1, asynchronous active-low reset.
- en, input, 1, monitoring enable.
- clr, input, 1, synchronous clear of counters and flags.
- a, input, 1, stimulus A as driven to the DUT.
- b, input, 1, stimulus B as driven to the DUT.
- q, input, 1, DUT output.
- toggle_cnt, output, CNT_W, number of q transitions seen while enabled; saturating.
- power_acc, output, PWR_W, toggle_cnt × ENERGY_PER_TOGGLE; saturating.
- err_cnt, output, CNT_W, number of failed checks; saturating.
- err_flag, output, 1, sticky; set on the first failed check.
- first_err_ab, output, 2, {a,b} captured at the first failed check.
- check_valid, output, 1, one-cycle pulse when a check is performed.
- state, output, 2, FSM state encoding: IDLE=0, SETTLE=1, CHECK=2, STABLE=3.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - All outputs clear to 0; FSM goes to IDLE.
  - Internal registers a_r, b_r, q_r, q_prev, ab_prev and settle_ctr clear to 0.
- Input sampling: a, b and q are registered once into a_r, b_r, q_r. All logic uses the registered values, so latency is 1 cycle from a pin change.
- Toggle/power counting:
  - Condition: en=1, state≠IDLE and q_r≠q_prev.
  - Action: toggle_cnt+1 and power_acc+ENERGY_PER_TOGGLE.
  - Both saturate at the all-ones value.
  - q_prev ← q_r every cycle, including in IDLE, so the first enabled cycle never counts a false toggle.
- FSM:
  - IDLE: ab_prev ← {a_r,b_r} each cycle. When en=1, load settle_ctr ← SETTLE_CYC−1 and go to SETTLE.
  - SETTLE:
    - If {a_r,b_r}≠ab_prev: reload settle_ctr, update ab_prev, stay in SETTLE.
    - Else if settle_ctr==0: go to CHECK.
    - Else: decrement settle_ctr.
  - CHECK (one cycle):
    - check_valid=1.
    - Mismatch is q_r ≠ ~(a_r|b_r).
    - On mismatch: err_cnt+1 (saturating) and err_flag←1.
    - If err_flag was 0 on that mismatch: first_err_ab←{a_r,b_r}.
    - Go to STABLE.
  - STABLE: if {a_r,b_r}≠ab_prev, update ab_prev, load settle_ctr and go to SETTLE. Otherwise hold.
- en=0 in any state: go to IDLE next cycle. Counter and flag values are held; no check is performed.
- clr=1:
  - Zeroes toggle_cnt, power_acc, err_cnt, err_flag and first_err_ab.
  - Overrides any increment in the same cycle.
  - Does not change FSM state.
- Simultaneous events:
  - An input change arriving on the cycle settle_ctr reaches 0 restarts SETTLE; no check is performed.
  - A q toggle during CHECK is counted, and the check uses that cycle's q_r.
- Mid-operation reset: outputs clear immediately; counting resumes only after en is seen again in IDLE.

Optional Feature:
- Macro: GATE_MON_HAZARD_EN.
- When defined:
  - Adds output hazard_cnt (CNT_W, saturating, reset 0, cleared by clr).
  - hazard_cnt increments once per SETTLE window in which q_r toggles two or more times, i.e. a glitch.
  - The per-window toggle tally resets on entry to SETTLE.
- When undefined: no port, no tally logic; behaviour is otherwise identical.

Test Plan (SETTLE_CYC=2, ENERGY_PER_TOGGLE=3):
1. Reset with q=1, then en=1 and a=b=0 held for 10 cycles.
   - Required: toggle_cnt=0, one check_valid pulse, err_cnt=0.
2. Four phases: {a,b}=00,01,10,11, 30 cycles each, q driven as a correct NOR.
   - Required: toggle_cnt=1, power_acc=3, four check_valid pulses, err_flag=0.
3. {a,b}=10 with q stuck at 1.
   - Required: err_cnt=1, err_flag=1, first_err_ab=2'b10.
   - A following {a,b}=11, also wrong, gives err_cnt=2 with first_err_ab unchanged.
4. Toggle a every cycle for 8 cycles.
   - Required: state stays SETTLE, no check_valid.
   - After a stops: exactly one check, arriving 3 cycles after the last registered change.
5. Assert clr in the same cycle as a q toggle.
   - Required: toggle_cnt=0, power_acc=0 next cycle. Separately, drop reset_L mid-SETTLE: all outputs are 0 asynchronously.
6. GATE_MON_HAZARD_EN defined: pulse q 1→0→1 inside one SETTLE window.
   - Required: hazard_cnt=1, toggle_cnt increases by 2.
